// File: rtl/dma_channel.sv
// Single memory-to-memory DMA channel with shadowed SRC/DST/CNT, triggered starts and completion irq.
// Optional feature: define DMA_REPEAT_EN to enable repeat-on-trigger with count/DST reload.
module dma_channel #(
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] reg_wdata,
  input  logic        reg_write,
  output logic [15:0] ctrl_rdata,
  input  logic        vblank_trig,
  input  logic        hblank_trig,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  mem_width,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ok,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_RD, S_WR, S_DONE} state_t;

  state_t           state_q;
  logic [31:0]      src_sh_q, dst_sh_q, src_q, dst_q;
  logic [CNT_W-1:0] cnt_sh_q, cnt_q;
  logic [15:0]      ctrl_q;
  logic             acc_q;
  logic             bus_req_q, mem_read_q, mem_write_q, irq_q, busy_q;
  logic [31:0]      mem_addr_q, mem_wdata_q;
  logic [1:0]       width_q;

  logic [31:0]      src_sh_d, dst_sh_d, src_nx, dst_nx;
  logic [CNT_W-1:0] cnt_sh_d;
  logic [15:0]      ctrl_d;
  logic             en_rise;

  function automatic logic [31:0] align(input logic [31:0] a, input logic word);
    align = word ? {a[31:2], 2'b00} : {a[31:1], 1'b0};
  endfunction

  // src modes 1x are fixed; dst mode 11 increments (the reload happens elsewhere)
  function automatic logic [31:0] step(input logic [31:0] a, input logic [1:0] mode,
                                       input logic word, input logic is_dst);
    logic [31:0] d;
    d = word ? 32'd4 : 32'd2;
    if (mode == 2'b01)                                step = a - d;
    else if (mode == 2'b00 || (is_dst && mode == 2'b11)) step = a + d;
    else                                              step = a;
  endfunction

  always_comb begin
    src_sh_d = src_sh_q;
    dst_sh_d = dst_sh_q;
    cnt_sh_d = cnt_sh_q;
    ctrl_d   = ctrl_q;
    if (reg_write) begin
      case (reg_sel)
        2'd0:    src_sh_d = reg_wdata;
        2'd1:    dst_sh_d = reg_wdata;
        2'd2:    cnt_sh_d = reg_wdata[CNT_W-1:0];
        default: ctrl_d   = {6'd0, reg_wdata[9:0]};
      endcase
    end
`ifndef DMA_REPEAT_EN
    ctrl_d[6] = 1'b0;
`endif
    en_rise = ctrl_d[0] & ~ctrl_q[0];
    src_nx  = step(src_q, ctrl_q[5:4], ctrl_q[1], 1'b0);
    dst_nx  = step(dst_q, ctrl_q[3:2], ctrl_q[1], 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      src_sh_q    <= '0;
      dst_sh_q    <= '0;
      cnt_sh_q    <= '0;
      ctrl_q      <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= 1'b0;
      bus_req_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      irq_q       <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      width_q     <= 2'd2;
    end else begin
      src_sh_q <= src_sh_d;
      dst_sh_q <= dst_sh_d;
      cnt_sh_q <= cnt_sh_d;
      ctrl_q   <= ctrl_d;
      irq_q    <= 1'b0;
      if (en_rise) begin
        src_q <= align(src_sh_d, ctrl_d[1]);
        dst_q <= align(dst_sh_d, ctrl_d[1]);
        cnt_q <= cnt_sh_d;
      end
      case (state_q)
        S_IDLE: begin
          if (ctrl_d[0]) begin
            if (ctrl_d[8:7] == 2'b00) begin
              state_q   <= S_REQ;
              bus_req_q <= 1'b1;
              busy_q    <= 1'b1;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!ctrl_q[0]) begin
            state_q <= S_IDLE;
          end else if ((ctrl_q[8:7] == 2'b01 && vblank_trig) ||
                       (ctrl_q[8:7] == 2'b10 && hblank_trig)) begin
            state_q   <= S_REQ;
            bus_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_REQ: begin
          if (!ctrl_q[0]) begin
            state_q   <= S_IDLE;
            bus_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (bus_gnt) begin
            state_q    <= S_RD;
            mem_read_q <= 1'b1;
            mem_addr_q <= src_q;
            width_q    <= ctrl_q[1] ? 2'd2 : 2'd1;
            acc_q      <= 1'b0;
          end
        end
        // acc_q marks that the access has already been held one cycle
        S_RD: begin
          if (acc_q && mem_ok) begin
            state_q     <= S_WR;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b1;
            mem_addr_q  <= dst_q;
            mem_wdata_q <= (width_q == 2'd2) ? mem_rdata : {mem_rdata[15:0], mem_rdata[15:0]};
            acc_q       <= 1'b0;
          end else begin
            acc_q <= 1'b1;
          end
        end
        S_WR: begin
          if (acc_q && mem_ok) begin
            src_q       <= src_nx;
            dst_q       <= dst_nx;
            cnt_q       <= cnt_q - CNT_W'(1);
            mem_write_q <= 1'b0;
            acc_q       <= 1'b0;
            if (!ctrl_q[0]) begin
              state_q   <= S_IDLE;
              bus_req_q <= 1'b0;
              busy_q    <= 1'b0;
            end else if (cnt_q == CNT_W'(1)) begin
              state_q   <= S_DONE;
              bus_req_q <= 1'b0;
              irq_q     <= ctrl_q[9];
            end else begin
              state_q    <= S_RD;
              mem_read_q <= 1'b1;
              mem_addr_q <= src_nx;
            end
          end else begin
            acc_q <= 1'b1;
          end
        end
        S_DONE: begin
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
          ctrl_q[0] <= 1'b0;
`ifdef DMA_REPEAT_EN
          if (ctrl_q[6] && ctrl_q[8:7] != 2'b00) begin
            state_q   <= S_WAIT;
            ctrl_q[0] <= ctrl_d[0];
            cnt_q     <= cnt_sh_q;
            if (ctrl_q[3:2] == 2'b11) dst_q <= align(dst_sh_q, ctrl_q[1]);
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ctrl_rdata = ctrl_q;
  assign bus_req    = bus_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_width  = width_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign busy       = busy_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_dma_channel.sv
// Directed bench for dma_channel (CNT_W = 4): word/halfword copies, stalls, triggers, disable, reset, count zero.
module tb_dma_channel;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  reg_sel = '0;
  logic [31:0] reg_wdata = '0;
  logic        reg_write = 1'b0;
  logic [15:0] ctrl_rdata;
  logic        vblank_trig = 1'b0, hblank_trig = 1'b0;
  logic        bus_req, bus_gnt = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_width;
  logic        mem_read, mem_write, mem_ok = 1'b1, busy, irq;

  int errors = 0;
  int checks = 0;

  dma_channel #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .reg_sel(reg_sel), .reg_wdata(reg_wdata), .reg_write(reg_write),
    .ctrl_rdata(ctrl_rdata), .vblank_trig(vblank_trig), .hblank_trig(hblank_trig),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_width(mem_width), .mem_read(mem_read), .mem_write(mem_write),
    .mem_ok(mem_ok), .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  // memory model: read data is a fixed function of the address
  assign mem_rdata = mem_addr + 32'h1111_0000;

  logic [31:0] rd_addr_q[$], wr_addr_q[$], wr_data_q[$];
  logic [1:0]  rd_w_q[$];
  int          irq_cnt = 0;
  logic        prev_rd = 1'b0, prev_wr = 1'b0;

  always @(negedge clk) begin
    if (mem_read && !prev_rd) begin
      rd_addr_q.push_back(mem_addr);
      rd_w_q.push_back(mem_width);
    end
    if (mem_write && !prev_wr) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (irq) irq_cnt++;
    prev_rd = mem_read;
    prev_wr = mem_write;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wreg(input logic [1:0] s, input logic [31:0] d);
    reg_sel = s; reg_wdata = d; reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic clear_logs();
    rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); rd_w_q.delete();
    irq_cnt = 0;
  endtask

  task automatic wait_irq(input string tag);
    int n;
    n = 0;
    while (!irq && n < 300) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, irq}, 32'd1);
  endtask

  initial begin
    int t, t_rd, n;
    logic [31:0] a0, d0;
    logic stable, left;

    // reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst bus_req", {31'd0, bus_req}, 0);
    chk("rst strobes", {30'd0, mem_read, mem_write}, 0);
    chk("rst irq/busy", {30'd0, irq, busy}, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_width", {30'd0, mem_width}, 2);
    chk("rst ctrl", {16'd0, ctrl_rdata}, 0);

    // immediate word copy, grant delayed two cycles
    clear_logs();
    wreg(2'd0, 32'h0300_0000);
    wreg(2'd1, 32'h0200_0000);
    wreg(2'd2, 32'd4);
    wreg(2'd3, 32'h203);
    chk("t1 bus_req after en", {31'd0, bus_req}, 1);
    chk("t1 busy after en", {31'd0, busy}, 1);
    tick(); tick();
    chk("t1 no read before gnt", {31'd0, mem_read}, 0);
    bus_gnt = 1'b1;
    t = 0; t_rd = -1;
    while (!irq && t < 200) begin
      tick();
      t++;
      if (mem_read && t_rd < 0) t_rd = t;
    end
    chk("t1 irq", {31'd0, irq}, 1);
    chk("t1 first RD cycle", t_rd, 1);
    chk("t1 RD-to-DONE cycles", t - t_rd, 16);
    chk("t1 bus_req low in DONE", {31'd0, bus_req}, 0);
    tick();
    chk("t1 irq one cycle", {31'd0, irq}, 0);
    chk("t1 busy idle", {31'd0, busy}, 0);
    chk("t1 ctrl en cleared", {16'd0, ctrl_rdata}, 32'h202);
    chk("t1 irq count", irq_cnt, 1);
    chk("t1 reads", rd_addr_q.size(), 4);
    chk("t1 writes", wr_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < rd_addr_q.size() && i < wr_addr_q.size(); i++) begin
      chk($sformatf("t1 rd addr %0d", i), rd_addr_q[i], 32'h0300_0000 + 32'(4 * i));
      chk($sformatf("t1 wr addr %0d", i), wr_addr_q[i], 32'h0200_0000 + 32'(4 * i));
      chk($sformatf("t1 wr data %0d", i), wr_data_q[i], 32'h1411_0000 + 32'(4 * i));
    end

    // halfword, source decrement, destination fixed
    clear_logs();
    wreg(2'd0, 32'h0300_0011);
    wreg(2'd1, 32'h0200_0100);
    wreg(2'd2, 32'd3);
    wreg(2'd3, 32'h219);
    wait_irq("t2 irq");
    tick();
    chk("t2 reads", rd_addr_q.size(), 3);
    chk("t2 writes", wr_addr_q.size(), 3);
    if (rd_addr_q.size() == 3 && wr_addr_q.size() == 3) begin
      chk("t2 rd addr 0", rd_addr_q[0], 32'h0300_0010);
      chk("t2 rd addr 1", rd_addr_q[1], 32'h0300_000E);
      chk("t2 rd addr 2", rd_addr_q[2], 32'h0300_000C);
      chk("t2 width", {30'd0, rd_w_q[0]}, 1);
      chk("t2 wr addr fixed", wr_addr_q[2], 32'h0200_0100);
      chk("t2 wr data 0", wr_data_q[0], 32'h0010_0010);
      chk("t2 wr data 2", wr_data_q[2], 32'h000C_000C);
    end

    // ready stall of 3 cycles inside the first WR
    clear_logs();
    wreg(2'd0, 32'h0300_0000);
    wreg(2'd1, 32'h0200_0000);
    wreg(2'd2, 32'd2);
    wreg(2'd3, 32'h203);
    n = 0;
    while (!mem_write && n < 50) begin
      tick();
      n++;
    end
    chk("t3 write seen", {31'd0, mem_write}, 1);
    a0 = mem_addr; d0 = mem_wdata;
    n = 1; stable = 1'b1; left = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 0) mem_ok = 1'b0;
      if (k == 3) mem_ok = 1'b1;
      if (mem_write && !left) begin
        n++;
        if (mem_addr !== a0 || mem_wdata !== d0) stable = 1'b0;
      end else begin
        left = 1'b1;
      end
    end
    mem_ok = 1'b1;
    chk("t3 WR cycles", n, 5);
    chk("t3 WR stable", {31'd0, stable}, 1);
    wait_irq("t3 irq");
    tick();
    chk("t3 units", wr_addr_q.size(), 2);

    // repeat bit storage
    wreg(2'd3, 32'h040);
`ifdef DMA_REPEAT_EN
    chk("rep bit stored", {16'd0, ctrl_rdata}, 32'h040);
`else
    chk("rep bit reads 0", {16'd0, ctrl_rdata}, 0);
`endif
    wreg(2'd3, 32'h000);

    // VBlank start, HBlank ignored, disable during 2nd RD of CNT=8
    clear_logs();
    wreg(2'd0, 32'h0300_0000);
    wreg(2'd1, 32'h0200_0000);
    wreg(2'd2, 32'd8);
    wreg(2'd3, 32'h283);
    tick();
    chk("t5 wait no req", {31'd0, bus_req}, 0);
    hblank_trig = 1'b1; tick(); hblank_trig = 1'b0;
    chk("t5 hblank ignored", {31'd0, bus_req}, 0);
    vblank_trig = 1'b1; tick(); vblank_trig = 1'b0;
    chk("t5 vblank req", {31'd0, bus_req}, 1);
    n = 0;
    while (rd_addr_q.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    wreg(2'd3, 32'h282);
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("t5 idle after disable", {31'd0, busy}, 0);
    chk("t5 units done", wr_addr_q.size(), 2);
    chk("t5 no further read", rd_addr_q.size(), 2);
    chk("t5 no irq", irq_cnt, 0);
    chk("t5 bus_req dropped", {31'd0, bus_req}, 0);

    // reset during RD
    wreg(2'd3, 32'h203);
    n = 0;
    while (!mem_read && n < 50) begin
      tick();
      n++;
    end
    chk("t6 read seen", {31'd0, mem_read}, 1);
    rst = 1'b1;
    tick();
    chk("t6 strobes after rst", {29'd0, mem_read, mem_write, bus_req}, 0);
    chk("t6 busy after rst", {31'd0, busy}, 0);
    rst = 1'b0;

    // count zero means 16 units at CNT_W = 4
    clear_logs();
    wreg(2'd0, 32'h0300_0000);
    wreg(2'd1, 32'h0200_0000);
    wreg(2'd2, 32'd0);
    wreg(2'd3, 32'h203);
    wait_irq("t7 irq");
    tick();
    chk("t7 reads", rd_addr_q.size(), 16);
    chk("t7 writes", wr_addr_q.size(), 16);
    if (wr_addr_q.size() == 16) chk("t7 last wr addr", wr_addr_q[15], 32'h0200_003C);

`ifdef DMA_REPEAT_EN
    // HBlank repeat with DST reload; trigger during WR ignored
    clear_logs();
    wreg(2'd2, 32'd2);
    wreg(2'd3, 32'h34F);
    tick(); tick();
    chk("t8 no req before trig", {31'd0, bus_req}, 0);
    hblank_trig = 1'b1; tick(); hblank_trig = 1'b0;
    chk("t8 req after trig", {31'd0, bus_req}, 1);
    wait_irq("t8 irq 1");
    chk("t8 en kept", {31'd0, ctrl_rdata[0]}, 1);
    tick();
    hblank_trig = 1'b1; tick(); hblank_trig = 1'b0;
    left = 1'b0; n = 0;
    while (!irq && n < 100) begin
      tick();
      n++;
      hblank_trig = mem_write && !left;
      if (mem_write) left = 1'b1;
    end
    hblank_trig = 1'b0;
    chk("t8 irq 2", {31'd0, irq}, 1);
    tick(); tick(); tick();
    chk("t8 WR trigger ignored", {31'd0, bus_req}, 0);
    chk("t8 writes", wr_addr_q.size(), 4);
    if (wr_addr_q.size() == 4) chk("t8 dst reload", wr_addr_q[2], 32'h0200_0000);
    wreg(2'd3, 32'h000);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
